// File: rtl/mem_arbiter.sv
// Two-master to one-port memory arbiter: the instruction-fetch and data buses share one
// external memory port. Ownership is registered and held until the memory acks.
module mem_arbiter #(
  parameter logic DATA_PRIORITY = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:1] instr_m_addr,
  output logic [15:0] instr_m_data_in,
  input  logic        instr_m_access,
  output logic        instr_m_ack,
  input  logic [19:1] data_m_addr,
  output logic [15:0] data_m_data_in,
  input  logic [15:0] data_m_data_out,
  input  logic        data_m_access,
  output logic        data_m_ack,
  input  logic        data_m_wr_en,
  input  logic [1:0]  data_m_bytesel,
  output logic [19:1] q_m_addr,
  input  logic [15:0] q_m_data_in,
  output logic [15:0] q_m_data_out,
  output logic        q_m_access,
  input  logic        q_m_ack,
  output logic        q_m_wr_en,
  output logic [1:0]  q_m_bytesel,
  output logic [1:0]  grant
);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    GRANT_INSTR = 2'd1,
    GRANT_DATA  = 2'd2
  } state_e;

  state_e state_q;
  state_e state_d;

  // Ownership register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next owner: fixed priority from IDLE, hand-over to the other requester on ack
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (instr_m_access && data_m_access) begin
          if (DATA_PRIORITY) begin
            state_d = GRANT_DATA;
          end else begin
            state_d = GRANT_INSTR;
          end
        end else if (data_m_access) begin
          state_d = GRANT_DATA;
        end else if (instr_m_access) begin
          state_d = GRANT_INSTR;
        end else begin
          state_d = IDLE;
        end
      end
      GRANT_INSTR: begin
        if (q_m_ack) begin
          if (data_m_access) begin
            state_d = GRANT_DATA;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = GRANT_INSTR;
        end
      end
      GRANT_DATA: begin
        if (q_m_ack) begin
          if (instr_m_access) begin
            state_d = GRANT_INSTR;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = GRANT_DATA;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Memory-port mux and ack routing; everything is quiet while no one owns the port
  always_comb begin
    q_m_addr     = 19'd0;
    q_m_data_out = 16'd0;
    q_m_access   = 1'b0;
    q_m_wr_en    = 1'b0;
    q_m_bytesel  = 2'b00;
    instr_m_ack  = 1'b0;
    data_m_ack   = 1'b0;
    grant        = 2'b00;
    case (state_q)
      GRANT_INSTR: begin
        q_m_addr     = instr_m_addr;
        q_m_access   = instr_m_access;
        q_m_bytesel  = 2'b11;
        instr_m_ack  = q_m_ack;
        grant        = 2'b01;
      end
      GRANT_DATA: begin
        q_m_addr     = data_m_addr;
        q_m_data_out = data_m_data_out;
        q_m_access   = data_m_access;
        q_m_wr_en    = data_m_wr_en;
        q_m_bytesel  = data_m_bytesel;
        data_m_ack   = q_m_ack;
        grant        = 2'b10;
      end
      default: begin
        grant = 2'b00;
      end
    endcase
  end

  // Read data is broadcast; each consumer qualifies it with its own ack.
  assign instr_m_data_in = q_m_data_in;
  assign data_m_data_in  = q_m_data_in;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: per-cycle vector table plus hand-written
// sequences for priority, contention, back-to-back and reset corner cases.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [19:1] iaddr;
  logic        ia;
  logic [19:1] daddr;
  logic [15:0] dwd;
  logic        da;
  logic        dwr;
  logic [1:0]  dbe;
  logic [15:0] qrd;
  logic        qack;

  logic [15:0] idata, ddata, qwd;
  logic        iack, dack, qacc, qwr;
  logic [19:1] qaddr;
  logic [1:0]  qbe, grant;

  logic [15:0] p0_idata, p0_ddata, p0_qwd;
  logic        p0_iack, p0_dack, p0_qacc, p0_qwr;
  logic [19:1] p0_qaddr;
  logic [1:0]  p0_qbe, p0_grant;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.DATA_PRIORITY(1'b1)) dut (
    .clk(clk), .reset(reset),
    .instr_m_addr(iaddr), .instr_m_data_in(idata), .instr_m_access(ia), .instr_m_ack(iack),
    .data_m_addr(daddr), .data_m_data_in(ddata), .data_m_data_out(dwd), .data_m_access(da),
    .data_m_ack(dack), .data_m_wr_en(dwr), .data_m_bytesel(dbe),
    .q_m_addr(qaddr), .q_m_data_in(qrd), .q_m_data_out(qwd), .q_m_access(qacc),
    .q_m_ack(qack), .q_m_wr_en(qwr), .q_m_bytesel(qbe), .grant(grant)
  );

  mem_arbiter #(.DATA_PRIORITY(1'b0)) dut_p0 (
    .clk(clk), .reset(reset),
    .instr_m_addr(iaddr), .instr_m_data_in(p0_idata), .instr_m_access(ia), .instr_m_ack(p0_iack),
    .data_m_addr(daddr), .data_m_data_in(p0_ddata), .data_m_data_out(dwd), .data_m_access(da),
    .data_m_ack(p0_dack), .data_m_wr_en(dwr), .data_m_bytesel(dbe),
    .q_m_addr(p0_qaddr), .q_m_data_in(qrd), .q_m_data_out(p0_qwd), .q_m_access(p0_qacc),
    .q_m_ack(qack), .q_m_wr_en(p0_qwr), .q_m_bytesel(p0_qbe), .grant(p0_grant)
  );

  typedef struct packed {
    logic        ia;
    logic [18:0] iaddr;
    logic        da;
    logic [18:0] daddr;
    logic        dwr;
    logic [1:0]  dbe;
    logic [15:0] dwd;
    logic        qack;
    logic [15:0] qrd;
    logic [1:0]  e_grant;
    logic        e_qacc;
    logic [18:0] e_qaddr;
    logic        e_qwr;
    logic [1:0]  e_qbe;
    logic [15:0] e_qwd;
    logic        e_iack;
    logic        e_dack;
  } vec_t;

  typedef struct packed {
    logic        is_data;
    logic [15:0] rdata;
  } exp_t;

  vec_t vecs [18];
  exp_t sb [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    ia = 1'b0; iaddr = 19'd0; da = 1'b0; daddr = 19'd0; dwr = 1'b0;
    dbe = 2'b00; dwd = 16'd0; qack = 1'b0; qrd = 16'd0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    exp_t e;
    logic ack_next;
    int   n_ack;
    int   idle_gaps;
    logic seen_grant;

    //           ia    iaddr       da    daddr       dwr   dbe    dwd        qack  qrd        grant  qacc  qaddr       qwr   qbe    qwd        iack  dack
    vecs[0]  = '{1'b0, 19'h00000, 1'b0, 19'h00000, 1'b0, 2'b00, 16'h0000, 1'b0, 16'h0000, 2'b00, 1'b0, 19'h00000, 1'b0, 2'b00, 16'h0000, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 19'h00100, 1'b0, 19'h00000, 1'b0, 2'b00, 16'h0000, 1'b0, 16'h0000, 2'b00, 1'b0, 19'h00000, 1'b0, 2'b00, 16'h0000, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 19'h00100, 1'b0, 19'h00000, 1'b0, 2'b00, 16'h0000, 1'b0, 16'h0000, 2'b01, 1'b1, 19'h00100, 1'b0, 2'b11, 16'h0000, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 19'h00100, 1'b0, 19'h00000, 1'b0, 2'b00, 16'h0000, 1'b1, 16'hBEEF, 2'b01, 1'b1, 19'h00100, 1'b0, 2'b11, 16'h0000, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 19'h00000, 1'b0, 19'h00000, 1'b0, 2'b00, 16'h0000, 1'b0, 16'h0000, 2'b00, 1'b0, 19'h00000, 1'b0, 2'b00, 16'h0000, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 19'h00000, 1'b0, 19'h00000, 1'b0, 2'b00, 16'h0000, 1'b1, 16'h1111, 2'b00, 1'b0, 19'h00000, 1'b0, 2'b00, 16'h0000, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 19'h00000, 1'b1, 19'h12345, 1'b1, 2'b10, 16'hA55A, 1'b0, 16'h0000, 2'b00, 1'b0, 19'h00000, 1'b0, 2'b00, 16'h0000, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 19'h00200, 1'b1, 19'h12345, 1'b1, 2'b10, 16'hA55A, 1'b0, 16'h0000, 2'b10, 1'b1, 19'h12345, 1'b1, 2'b10, 16'hA55A, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 19'h00200, 1'b1, 19'h12345, 1'b1, 2'b10, 16'hA55A, 1'b0, 16'h0000, 2'b10, 1'b1, 19'h12345, 1'b1, 2'b10, 16'hA55A, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 19'h00200, 1'b1, 19'h12345, 1'b1, 2'b10, 16'hA55A, 1'b1, 16'h1234, 2'b10, 1'b1, 19'h12345, 1'b1, 2'b10, 16'hA55A, 1'b0, 1'b1};
    vecs[10] = '{1'b1, 19'h00200, 1'b0, 19'h12345, 1'b1, 2'b10, 16'hA55A, 1'b0, 16'h0000, 2'b01, 1'b1, 19'h00200, 1'b0, 2'b11, 16'h0000, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 19'h00200, 1'b0, 19'h00000, 1'b0, 2'b00, 16'h0000, 1'b1, 16'h5A5A, 2'b01, 1'b1, 19'h00200, 1'b0, 2'b11, 16'h0000, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 19'h00000, 1'b0, 19'h00000, 1'b0, 2'b00, 16'h0000, 1'b0, 16'h0000, 2'b00, 1'b0, 19'h00000, 1'b0, 2'b00, 16'h0000, 1'b0, 1'b0};
    vecs[13] = '{1'b1, 19'h00300, 1'b0, 19'h00000, 1'b0, 2'b00, 16'h0000, 1'b0, 16'h0000, 2'b00, 1'b0, 19'h00000, 1'b0, 2'b00, 16'h0000, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 19'h00300, 1'b0, 19'h00000, 1'b0, 2'b00, 16'h0000, 1'b0, 16'h0000, 2'b01, 1'b0, 19'h00300, 1'b0, 2'b11, 16'h0000, 1'b0, 1'b0};
    vecs[15] = '{1'b0, 19'h00300, 1'b1, 19'h00040, 1'b0, 2'b01, 16'h0000, 1'b0, 16'h0000, 2'b01, 1'b0, 19'h00300, 1'b0, 2'b11, 16'h0000, 1'b0, 1'b0};
    vecs[16] = '{1'b0, 19'h00300, 1'b0, 19'h00000, 1'b0, 2'b00, 16'h0000, 1'b1, 16'h7777, 2'b01, 1'b0, 19'h00300, 1'b0, 2'b11, 16'h0000, 1'b1, 1'b0};
    vecs[17] = '{1'b0, 19'h00000, 1'b0, 19'h00000, 1'b0, 2'b00, 16'h0000, 1'b0, 16'h0000, 2'b00, 1'b0, 19'h00000, 1'b0, 2'b00, 16'h0000, 1'b0, 1'b0};

    do_reset();
    for (int i = 0; i < 18; i++) begin
      ia = vecs[i].ia; iaddr = vecs[i].iaddr; da = vecs[i].da; daddr = vecs[i].daddr;
      dwr = vecs[i].dwr; dbe = vecs[i].dbe; dwd = vecs[i].dwd;
      qack = vecs[i].qack; qrd = vecs[i].qrd;
      @(negedge clk);
      chk($sformatf("v%0d_grant", i), {30'd0, grant}, {30'd0, vecs[i].e_grant});
      chk($sformatf("v%0d_qacc", i), {31'd0, qacc}, {31'd0, vecs[i].e_qacc});
      chk($sformatf("v%0d_qaddr", i), {13'd0, qaddr}, {13'd0, vecs[i].e_qaddr});
      chk($sformatf("v%0d_qwr", i), {31'd0, qwr}, {31'd0, vecs[i].e_qwr});
      chk($sformatf("v%0d_qbe", i), {30'd0, qbe}, {30'd0, vecs[i].e_qbe});
      chk($sformatf("v%0d_qwd", i), {16'd0, qwd}, {16'd0, vecs[i].e_qwd});
      chk($sformatf("v%0d_acks", i), {30'd0, dack, iack}, {30'd0, vecs[i].e_dack, vecs[i].e_iack});
      chk($sformatf("v%0d_rdata", i), {ddata, idata}, {vecs[i].qrd, vecs[i].qrd});
      next_cycle();
    end

    // Priority from IDLE with both pending, and immediate hand-over on ack
    do_reset();
    ia = 1'b1; iaddr = 19'h00010; da = 1'b1; daddr = 19'h00020; dbe = 2'b01;
    @(negedge clk);
    chk("prio_idle", {28'd0, p0_grant, grant}, 32'd0);
    next_cycle();
    @(negedge clk);
    chk("prio1_grant", {30'd0, grant}, 32'd2);
    chk("prio1_addr", {13'd0, qaddr}, 32'h00020);
    chk("prio0_grant", {30'd0, p0_grant}, 32'd1);
    chk("prio0_addr", {13'd0, p0_qaddr}, 32'h00010);
    next_cycle();
    qack = 1'b1; qrd = 16'h2222;
    @(negedge clk);
    chk("prio1_ack", {30'd0, dack, iack}, 32'd2);
    chk("prio0_ack", {30'd0, p0_dack, p0_iack}, 32'd1);
    chk("prio0_rdata", {16'd0, p0_idata}, 32'h2222);
    next_cycle();
    qack = 1'b0;
    @(negedge clk);
    chk("prio1_handover", {30'd0, grant}, 32'd1);
    chk("prio0_handover", {30'd0, p0_grant}, 32'd2);
    chk("prio0_qwd", {15'd0, p0_qwr, p0_qbe, p0_qwd}, 32'h10000);
    chk("prio0_qacc", {31'd0, p0_qacc}, 32'd1);

    // Continuous contention: memory acks on the second cycle of each access
    do_reset();
    ia = 1'b1; iaddr = 19'h0AAAA; da = 1'b1; daddr = 19'h05555; dbe = 2'b11;
    for (int n = 0; n < 10; n++) begin
      e.is_data = (n % 2 == 0);
      e.rdata = 16'hC000 + 16'(n);
      sb.push_back(e);
    end
    ack_next = 1'b0; n_ack = 0; idle_gaps = 0; seen_grant = 1'b0;
    for (int cyc = 0; cyc < 60 && sb.size() > 0; cyc++) begin
      qack = ack_next;
      qrd = 16'hC000 + 16'(n_ack);
      @(negedge clk);
      if (qack) begin
        e = sb.pop_front();
        chk($sformatf("alt%0d_owner", n_ack), {30'd0, dack, iack}, e.is_data ? 32'd2 : 32'd1);
        chk($sformatf("alt%0d_rdata", n_ack), {16'd0, e.is_data ? ddata : idata}, {16'd0, e.rdata});
        n_ack++;
      end
      if (grant != 2'b00) begin
        seen_grant = 1'b1;
      end else if (seen_grant) begin
        idle_gaps++;
      end
      ack_next = qacc && !qack;
      next_cycle();
    end
    chk("alt_drained", sb.size(), 32'd0);
    chk("alt_no_idle", idle_gaps, 32'd0);

    // Single requester back-to-back: one IDLE cycle after every ack
    do_reset();
    da = 1'b1; daddr = 19'h00444; dbe = 2'b11;
    @(negedge clk);
    chk("b2b_start_idle", {30'd0, grant}, 32'd0);
    for (int t = 0; t < 3; t++) begin
      next_cycle();
      @(negedge clk);
      chk($sformatf("b2b%0d_grant", t), {30'd0, grant}, 32'd2);
      next_cycle();
      qack = 1'b1; qrd = 16'h4400 + 16'(t);
      @(negedge clk);
      chk($sformatf("b2b%0d_ack", t), {30'd0, dack, iack}, 32'd2);
      chk($sformatf("b2b%0d_rdata", t), {16'd0, ddata}, 32'h4400 + t);
      next_cycle();
      qack = 1'b0;
      @(negedge clk);
      chk($sformatf("b2b%0d_idle", t), {31'd0, qacc, grant}, 32'd0);
    end

    // Reset mid-transaction, then a stale ack must be dropped
    do_reset();
    da = 1'b1; daddr = 19'h00555; dwr = 1'b1; dbe = 2'b11; dwd = 16'h1234;
    next_cycle();
    @(negedge clk);
    chk("rst_granted", {29'd0, qacc, grant}, 32'h6);
    next_cycle();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0; da = 1'b0; qack = 1'b1; qrd = 16'h9999;
    @(negedge clk);
    chk("rst_grant", {30'd0, grant}, 32'd0);
    chk("rst_qout", {13'd0, qacc, qwr, qbe, qwd[14:0]}, 32'd0);
    chk("rst_late_ack", {30'd0, dack, iack}, 32'd0);
    chk("rst_qaddr", {13'd0, qaddr}, 32'd0);
    next_cycle();
    qack = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
